// File: rtl/soc_pll_rstgen.sv
// rtl/soc_pll_rstgen.sv - PLL reset, lock qualification and ordered domain reset release
module soc_pll_rstgen #(
    parameter int PLL_RST_CYCLES = 32,
    parameter int LOCK_FILTER    = 1024,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STAGE_GAP      = 16,
    parameter int MAX_RETRIES    = 8
) (
    input  logic       i_clk_50m,
    input  logic       i_rst,
    input  logic       i_pll_lock,
    input  logic       i_sw_reset,
    output logic       o_pll_rst,
    output logic       o_rtc_rst,
    output logic       o_bus_rst,
    output logic       o_ddr_rst,
    output logic       o_core_rst,
    output logic       o_ready,
    output logic       o_fail,
    output logic [3:0] o_retry_cnt
);
    // One shared counter serves the PLL reset pulse, the lock filter and the stage gap.
    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_FILTER) ? PLL_RST_CYCLES : LOCK_FILTER;
    localparam int CNT_MAX   = (CNT_MAX_A > STAGE_GAP) ? CNT_MAX_A : STAGE_GAP;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int TMR_W     = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_FILTER,
        ST_RELEASE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic             w_lock_s;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [TMR_W-1:0] w_timer_inc;
    logic             w_timeout;
    logic [1:0]       r_stage;
    logic [1:0]       w_stage_nxt;
    logic             r_pll_rst;
    logic             w_pll_rst_nxt;
    logic [3:0]       r_dom_rst;      // [0]=rtc [1]=bus [2]=ddr [3]=core
    logic [3:0]       w_dom_rst_nxt;
    logic             r_ready;
    logic             w_ready_nxt;
    logic             r_fail;
    logic             w_fail_nxt;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_nxt;
    logic [3:0]       w_retry_inc;
    logic             w_restart;
    logic             w_attempt_fail;

    // Two-flop synchroniser bringing the asynchronous PLL lock into the reference domain
    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s    = r_sync2;
    // The timer saturates so a lock that wins a timeout tie still times out if it later drops.
    assign w_timeout   = (r_timer >= TMR_LAST);
    assign w_timer_inc = w_timeout ? r_timer : (r_timer + TMR_W'(1));
    assign w_retry_inc = r_retry + 4'd1;

    // State register plus all sequencer counters and registered outputs
    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_PLL_RST;
            r_cnt     <= '0;
            r_timer   <= '0;
            r_stage   <= '0;
            r_pll_rst <= 1'b1;
            r_dom_rst <= 4'hF;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
            r_retry   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timer   <= w_timer_nxt;
            r_stage   <= w_stage_nxt;
            r_pll_rst <= w_pll_rst_nxt;
            r_dom_rst <= w_dom_rst_nxt;
            r_ready   <= w_ready_nxt;
            r_fail    <= w_fail_nxt;
            r_retry   <= w_retry_nxt;
        end
    end

    // Next-state and next-output logic; software reset outranks every other transition
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_timer_nxt    = r_timer;
        w_stage_nxt    = r_stage;
        w_pll_rst_nxt  = r_pll_rst;
        w_dom_rst_nxt  = r_dom_rst;
        w_ready_nxt    = r_ready;
        w_fail_nxt     = r_fail;
        w_retry_nxt    = r_retry;
        w_restart      = 1'b0;
        w_attempt_fail = 1'b0;

        if (i_sw_reset) begin
            w_restart   = 1'b1;
            w_retry_nxt = '0;
            w_fail_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_nxt   = ST_WAIT_LOCK;
                        w_pll_rst_nxt = 1'b0;
                        w_cnt_nxt     = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    w_timer_nxt = w_timer_inc;
                    if (w_lock_s) begin
                        w_state_nxt = ST_FILTER;
                        w_cnt_nxt   = '0;
                    end else if (w_timeout) begin
                        w_attempt_fail = 1'b1;
                    end
                end
                ST_FILTER: begin
                    w_timer_nxt = w_timer_inc;
                    if (w_lock_s) begin
                        if (r_cnt == FILT_LAST) begin
                            w_state_nxt      = ST_RELEASE;
                            w_dom_rst_nxt[0] = 1'b0;
                            w_cnt_nxt        = '0;
                            w_stage_nxt      = 2'd1;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else if (w_timeout) begin
                        w_attempt_fail = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_RELEASE: begin
                    if (!w_lock_s) begin
                        w_restart = 1'b1;
                    end else if (r_cnt == GAP_LAST) begin
                        w_cnt_nxt                = '0;
                        w_dom_rst_nxt[r_stage]   = 1'b0;
                        if (r_stage == 2'd3) begin
                            w_state_nxt = ST_RUN;
                            w_ready_nxt = 1'b1;
                            w_retry_nxt = '0;
                        end else begin
                            w_stage_nxt = r_stage + 2'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        w_restart = 1'b1;
                    end
                end
                ST_FAIL: begin
                    w_pll_rst_nxt = 1'b1;
                end
                default: begin
                    w_restart = 1'b1;
                end
            endcase

            if (w_attempt_fail) begin
                w_retry_nxt = w_retry_inc;
                if (w_retry_inc == RETRY_MAX) begin
                    w_state_nxt   = ST_FAIL;
                    w_fail_nxt    = 1'b1;
                    w_pll_rst_nxt = 1'b1;
                    w_dom_rst_nxt = 4'hF;
                    w_ready_nxt   = 1'b0;
                end else begin
                    w_restart = 1'b1;
                end
            end
        end

        // Every path back to PLL_RST reasserts all domains together and restarts the timer.
        if (w_restart) begin
            w_state_nxt   = ST_PLL_RST;
            w_cnt_nxt     = '0;
            w_timer_nxt   = '0;
            w_stage_nxt   = '0;
            w_pll_rst_nxt = 1'b1;
            w_dom_rst_nxt = 4'hF;
            w_ready_nxt   = 1'b0;
        end
    end

    assign o_pll_rst   = r_pll_rst;
    assign o_rtc_rst   = r_dom_rst[0];
    assign o_bus_rst   = r_dom_rst[1];
    assign o_ddr_rst   = r_dom_rst[2];
    assign o_core_rst  = r_dom_rst[3];
    assign o_ready     = r_ready;
    assign o_fail      = r_fail;
    assign o_retry_cnt = r_retry;

endmodule

// File: tb/tb_soc_pll_rstgen.sv
// tb/tb_soc_pll_rstgen.sv - directed scenario bench for soc_pll_rstgen
module tb_soc_pll_rstgen;
    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_pll_lock = 1'b0;
    logic       i_sw_reset = 1'b0;
    logic       o_pll_rst;
    logic       o_rtc_rst;
    logic       o_bus_rst;
    logic       o_ddr_rst;
    logic       o_core_rst;
    logic       o_ready;
    logic       o_fail;
    logic [3:0] o_retry_cnt;

    int vectors = 0;
    int miscompares = 0;

    soc_pll_rstgen #(
        .PLL_RST_CYCLES(4),
        .LOCK_FILTER   (8),
        .LOCK_TIMEOUT  (64),
        .STAGE_GAP     (2),
        .MAX_RETRIES   (3)
    ) dut (
        .i_clk_50m  (clk),
        .i_rst      (i_rst),
        .i_pll_lock (i_pll_lock),
        .i_sw_reset (i_sw_reset),
        .o_pll_rst  (o_pll_rst),
        .o_rtc_rst  (o_rtc_rst),
        .o_bus_rst  (o_bus_rst),
        .o_ddr_rst  (o_ddr_rst),
        .o_core_rst (o_core_rst),
        .o_ready    (o_ready),
        .o_fail     (o_fail),
        .o_retry_cnt(o_retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst      = 1'b1;
        i_pll_lock = 1'b0;
        i_sw_reset = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        #1 i_rst = 1'b1;
        #2;
        got = {o_pll_rst, o_rtc_rst, o_bus_rst, o_ddr_rst, o_core_rst, o_ready, o_fail, o_retry_cnt};
        vectors++;
        if (got !== 11'b1_1111_0_0_0000) begin
            miscompares++;
            $display("FAIL reset_initial: got %b want %b", got, 11'b1_1111_0_0_0000);
        end
        tick();
        tick();
        got = {o_pll_rst, o_rtc_rst, o_bus_rst, o_ddr_rst, o_core_rst, o_ready, o_fail, o_retry_cnt};
        vectors++;
        if (got !== 11'b1_1111_0_0_0000) begin
            miscompares++;
            $display("FAIL reset_held: got %b want %b", got, 11'b1_1111_0_0_0000);
        end
    endtask

    task automatic test_nominal();
        logic [4:0] want;
        logic [4:0] got;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++;
            if (o_pll_rst !== (k < 4)) begin
                miscompares++;
                $display("FAIL nominal_pll_rst edge %0d: got %b want %b", k, o_pll_rst, (k < 4));
            end
        end
        for (int k = 0; k < 10; k++) tick();
        i_pll_lock = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            tick();
            want = {(k < 10), (k < 12), (k < 14), (k < 16), (k >= 16)};
            got  = {o_rtc_rst, o_bus_rst, o_ddr_rst, o_core_rst, o_ready};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL nominal_release edge %0d: got %b want %b", k, got, want);
            end
        end
        vectors++;
        if ({o_pll_rst, o_fail, o_retry_cnt} !== 6'b0_0_0000) begin
            miscompares++;
            $display("FAIL nominal_run_status: got %b want %b", {o_pll_rst, o_fail, o_retry_cnt}, 6'b0);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k <= 17; k++) begin
            i_pll_lock = (k != 5);
            tick();
            vectors++;
            if (o_rtc_rst !== (k < 16)) begin
                miscompares++;
                $display("FAIL glitch_rtc edge %0d: got %b want %b", k, o_rtc_rst, (k < 16));
            end
        end
        vectors++;
        if ({o_bus_rst, o_retry_cnt} !== 5'b1_0000) begin
            miscompares++;
            $display("FAIL glitch_bus_retry: got %b want %b", {o_bus_rst, o_retry_cnt}, 5'b1_0000);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        for (int n = 1; n <= 3; n++) begin
            for (int k = 0; k < 63; k++) tick();
            vectors++;
            if ({o_pll_rst, o_retry_cnt} !== {1'b0, 4'(n - 1)}) begin
                miscompares++;
                $display("FAIL timeout_before attempt %0d: got %b want %b", n, {o_pll_rst, o_retry_cnt}, {1'b0, 4'(n - 1)});
            end
            tick();
            vectors++;
            if ({o_pll_rst, o_retry_cnt} !== {1'b1, 4'(n)}) begin
                miscompares++;
                $display("FAIL timeout_expire attempt %0d: got %b want %b", n, {o_pll_rst, o_retry_cnt}, {1'b1, 4'(n)});
            end
            if (n < 3) begin
                for (int k = 0; k < 3; k++) tick();
                vectors++;
                if (o_pll_rst !== 1'b1) begin
                    miscompares++;
                    $display("FAIL timeout_pulse_hold attempt %0d: got %b want 1", n, o_pll_rst);
                end
                tick();
                vectors++;
                if (o_pll_rst !== 1'b0) begin
                    miscompares++;
                    $display("FAIL timeout_pulse_end attempt %0d: got %b want 0", n, o_pll_rst);
                end
            end
        end
        vectors++;
        if (o_fail !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_fail_set: got %b want 1", o_fail);
        end
        for (int k = 0; k < 20; k++) tick();
        vectors++;
        if ({o_pll_rst, o_fail, o_retry_cnt, o_rtc_rst, o_bus_rst, o_ddr_rst, o_core_rst, o_ready} !== 11'b1_1_0011_1111_0) begin
            miscompares++;
            $display("FAIL timeout_fail_hold: got %b want %b",
                     {o_pll_rst, o_fail, o_retry_cnt, o_rtc_rst, o_bus_rst, o_ddr_rst, o_core_rst, o_ready}, 11'b1_1_0011_1111_0);
        end
        i_sw_reset = 1'b1;
        tick();
        i_sw_reset = 1'b0;
        vectors++;
        if ({o_fail, o_retry_cnt, o_pll_rst} !== 6'b0_0000_1) begin
            miscompares++;
            $display("FAIL timeout_sw_clear: got %b want %b", {o_fail, o_retry_cnt, o_pll_rst}, 6'b0_0000_1);
        end
        for (int k = 0; k < 4; k++) tick();
        vectors++;
        if (o_pll_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_sw_rerun: got %b want 0", o_pll_rst);
        end
    endtask

    task automatic test_lock_loss();
        logic reached;
        do_reset();
        i_pll_lock = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 100 && !reached; k++) begin
            tick();
            if (o_ready === 1'b1) reached = 1'b1;
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL loss_reach_run: got ready %b want 1", o_ready);
        end
        i_pll_lock = 1'b0;
        tick();
        i_pll_lock = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            vectors++;
            if ({o_rtc_rst, o_bus_rst, o_ddr_rst, o_core_rst, o_ready} !== 5'b0000_1) begin
                miscompares++;
                $display("FAIL loss_early edge %0d: got %b want %b", k,
                         {o_rtc_rst, o_bus_rst, o_ddr_rst, o_core_rst, o_ready}, 5'b0000_1);
            end
            tick();
        end
        vectors++;
        if ({o_rtc_rst, o_bus_rst, o_ddr_rst, o_core_rst, o_ready, o_pll_rst} !== 6'b1111_0_1) begin
            miscompares++;
            $display("FAIL loss_reassert: got %b want %b",
                     {o_rtc_rst, o_bus_rst, o_ddr_rst, o_core_rst, o_ready, o_pll_rst}, 6'b1111_0_1);
        end
        for (int k = 0; k < 3; k++) tick();
        vectors++;
        if (o_pll_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL loss_pll_pulse: got %b want 1", o_pll_rst);
        end
        tick();
        vectors++;
        if (o_pll_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL loss_pll_end: got %b want 0", o_pll_rst);
        end
        for (int k = 0; k < 8; k++) tick();
        vectors++;
        if (o_rtc_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL loss_rtc_early: got %b want 1", o_rtc_rst);
        end
        tick();
        vectors++;
        if (o_rtc_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL loss_rtc_release: got %b want 0", o_rtc_rst);
        end
        for (int k = 0; k < 6; k++) tick();
        vectors++;
        if ({o_ready, o_core_rst, o_retry_cnt} !== 6'b1_0_0000) begin
            miscompares++;
            $display("FAIL loss_rerun_ready: got %b want %b", {o_ready, o_core_rst, o_retry_cnt}, 6'b1_0_0000);
        end
    endtask

    task automatic test_sw_mid_release();
        logic       reached;
        logic [4:0] want;
        logic [4:0] got;
        do_reset();
        i_pll_lock = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 100 && !reached; k++) begin
            tick();
            if (o_rtc_rst === 1'b0) reached = 1'b1;
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL sw_reach_release: got rtc %b want 0", o_rtc_rst);
        end
        i_sw_reset = 1'b1;
        tick();
        i_sw_reset = 1'b0;
        vectors++;
        if ({o_rtc_rst, o_bus_rst, o_pll_rst, o_ready} !== 4'b1110) begin
            miscompares++;
            $display("FAIL sw_abort: got %b want %b", {o_rtc_rst, o_bus_rst, o_pll_rst, o_ready}, 4'b1110);
        end
        for (int k = 1; k <= 19; k++) begin
            tick();
            want = {(k < 13), (k < 15), (k < 17), (k < 19), (k >= 19)};
            got  = {o_rtc_rst, o_bus_rst, o_ddr_rst, o_core_rst, o_ready};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL sw_rerun edge %0d: got %b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        logic reached;
        logic [10:0] got;
        do_reset();
        i_pll_lock = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 100 && !reached; k++) begin
            tick();
            if (o_ready === 1'b1) reached = 1'b1;
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL async_reach_run: got ready %b want 1", o_ready);
        end
        #2;
        i_rst = 1'b1;
        #1;
        got = {o_pll_rst, o_rtc_rst, o_bus_rst, o_ddr_rst, o_core_rst, o_ready, o_fail, o_retry_cnt};
        vectors++;
        if (got !== 11'b1_1111_0_0_0000) begin
            miscompares++;
            $display("FAIL async_reset_immediate: got %b want %b", got, 11'b1_1111_0_0_0000);
        end
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        vectors++;
        if (o_pll_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL async_restart_pll: got %b want 0", o_pll_rst);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout();
        test_lock_loss();
        test_sw_mid_release();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/soc_pll_rstgen.md
Name: soc_pll_rstgen

Overview:
Reset and lock sequencer sitting directly in front of soc_pll, clocked by the free-running 50 MHz reference. It drives the PLL reset and qualifies the PLL lock with a stability filter, a timeout and bounded retries. Once lock is qualified it releases the per-domain resets in a fixed order: rtc, bus, ddr, core. Each output is a request that the consuming domain synchronises locally.

Parameters:
PLL_RST_CYCLES, 32, cycles o_pll_rst is held high per attempt (>=1)
LOCK_FILTER, 1024, consecutive cycles synced lock must stay high to count as qualified (>=1)
LOCK_TIMEOUT, 50000, cycles allowed from PLL reset release to qualified lock (1 ms)
STAGE_GAP, 16, cycles between successive domain reset releases (>=1)
MAX_RETRIES, 8, failed lock attempts tolerated before FAIL (1..15)

Ports:
i_clk_50m  in  1  reference clock; all logic runs on it
i_rst  in  1  asynchronous, active-high reset
i_pll_lock  in  1  PLL LOCK, asynchronous to i_clk_50m
i_sw_reset  in  1  single-cycle request to rerun the full sequence
o_pll_rst  out  1  PLL RESET
o_rtc_rst  out  1  rtc-domain reset request, active-high
o_bus_rst  out  1  bus-domain reset request, active-high
o_ddr_rst  out  1  ddr-domain reset request, active-high
o_core_rst  out  1  core-domain reset request, active-high
o_ready  out  1  all domains out of reset, lock qualified
o_fail  out  1  retries exhausted
o_retry_cnt  out  4  failed attempts in the current sequence

Behaviour:
- Reset values: o_pll_rst=1, all o_*_rst=1, o_ready=0, o_fail=0, o_retry_cnt=0, state=PLL_RST, all counters 0.
- Lock synchroniser: i_pll_lock passes through a 2-FF synchroniser (flops reset to 0) to produce lock_s. Latency is 2 edges. All decisions use lock_s only.
- Timeout timer: counts cycles spent in WAIT_LOCK plus FILTER. It is cleared on each entry to PLL_RST.
- PLL_RST: o_pll_rst=1. After PLL_RST_CYCLES edges, go to WAIT_LOCK and drive o_pll_rst=0.
- WAIT_LOCK:
  - If lock_s=1, go to FILTER with the filter counter at 0.
  - Otherwise, when the timer reaches LOCK_TIMEOUT-1, increment o_retry_cnt. If the new value equals MAX_RETRIES, go to FAIL; else go to PLL_RST.
- FILTER:
  - On each edge with lock_s=1: if the filter counter equals LOCK_FILTER-1, go to RELEASE and drive o_rtc_rst=0 on that same edge; otherwise increment the counter.
  - lock_s=0 returns to WAIT_LOCK. The timer keeps running, so a glitching lock still times out.
  - The timeout check also applies in FILTER and uses the WAIT_LOCK timeout rule.
- RELEASE: every STAGE_GAP edges, deassert the next reset in order bus, ddr, core. On the edge core deasserts, go to RUN, set o_ready=1 and clear o_retry_cnt to 0.
- RUN: hold all resets low with o_ready=1.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - On the next edge, all four domain resets go to 1 and o_ready goes to 0.
  - State goes to PLL_RST.
  - o_retry_cnt is not incremented; a loss after success is not a failed attempt.
- i_sw_reset in any state other than FAIL: identical to lock loss. o_retry_cnt is cleared and the timer restarts.
- FAIL: o_pll_rst=1, all domain resets 1, o_fail=1. Only i_sw_reset (which clears o_fail and o_retry_cnt and goes to PLL_RST) or i_rst exits FAIL.
- Simultaneous events: i_sw_reset has priority over every other transition. A timeout and lock_s=1 in the same cycle resolve in favour of lock.
- Ordering invariant: domain resets deassert strictly in the order rtc, bus, ddr, core, and all reassert together in one edge.
- An asynchronous i_rst forces the reset values immediately, in any state and mid-sequence.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=64, STAGE_GAP=2, MAX_RETRIES=3. Edge 0 is the first edge sampling i_pll_lock=1.
1. Nominal bring-up: release i_rst and raise i_pll_lock 10 cycles after o_pll_rst falls. Required: o_rtc_rst falls at edge 10, o_bus_rst at 12, o_ddr_rst at 14, o_core_rst and o_ready=1 at 16.
2. Lock glitch: i_pll_lock high 5 cycles, low 1, then steady. Required: no reset deasserts until 8 consecutive lock_s cycles; rtc falls exactly 10 edges after the final rise.
3. Timeout and retry: i_pll_lock held 0. Required: o_pll_rst pulses high for 4 cycles after every 64 low-lock cycles. o_retry_cnt steps 1, 2, then at 3 o_fail=1 with o_pll_rst stuck high. i_sw_reset then clears o_fail and o_retry_cnt=0.
4. Lock loss in RUN: drop i_pll_lock for 1 cycle. Required: all four resets reach 1 and o_ready reaches 0 together, 3 edges after the drop. o_pll_rst pulses for 4 cycles, then the sequence repeats and o_retry_cnt stays 0.
5. i_sw_reset mid-RELEASE, asserted the edge after rtc deasserts. Required: rtc reasserts on the next edge, bus is never released, and the full sequence reruns.
6. Asynchronous i_rst mid-RUN, between clock edges. Required: all outputs reach reset values immediately without waiting for an edge.
